// File: rtl/acc_multichan.sv
// acc_multichan: multi-channel tile accumulator sharing one pipelined adder.
// Each channel sums AccLen beats; completed tiles leave through a small
// ready/valid FIFO tagged with their channel.
// Build option: ACC_INT_ADD_EN selects the internal wrapping integer adder
// (AddLatency stages); without it the FP_ADD single-precision adder
// (7 stages, DataWidth 32) is used.
// OutDepth must be a power of 2 and at least 2.

`ifndef ACC_INT_ADD_EN
// FP_ADD: IEEE-754 single adder, 7-cycle latency. Denormals flush to zero,
// round-to-nearest-even. The add is done in the first stage; the remaining
// stages only carry the result.
module FP_ADD (
  input  logic        clk,
  input  logic        aclr,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);
  localparam int Stages = 7;

  logic [Stages-1:0][31:0] pipe_q;
  logic               sa, sb, sl, ss, swap, fnd, rnd;
  logic [7:0]         ea, eb, el, es, d;
  logic [23:0]        ma, mb, ml, ms;
  logic [26:0]        sh_in, sm, norm;
  logic [27:0]        sum28;
  logic [24:0]        mr;
  logic [4:0]         lz;
  logic signed [9:0]  ex;
  logic               nan_a, nan_b, inf_a, inf_b;
  logic [31:0]        res;

  // Unpack, align, add, normalise and round in one combinational step.
  always_comb begin
    sa = a[31]; sb = b[31]; ea = a[30:23]; eb = b[30:23];
    ma = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    mb = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    nan_a = (ea == 8'hFF) && (a[22:0] != 23'd0);
    nan_b = (eb == 8'hFF) && (b[22:0] != 23'd0);
    inf_a = (ea == 8'hFF) && (a[22:0] == 23'd0);
    inf_b = (eb == 8'hFF) && (b[22:0] == 23'd0);
    swap = {eb, mb} > {ea, ma};
    sl = swap ? sb : sa;  el = swap ? eb : ea;  ml = swap ? mb : ma;
    ss = swap ? sa : sb;  es = swap ? ea : eb;  ms = swap ? ma : mb;
    d = el - es;
    sh_in = {ms, 3'b000};
    sm = sh_in >> d;
    sm[0] = sm[0] | (|(sh_in & ((27'd1 << d) - 27'd1)));
    if (sl == ss) sum28 = {1'b0, ml, 3'b000} + {1'b0, sm};
    else          sum28 = {1'b0, ml, 3'b000} - {1'b0, sm};
    ex = $signed({2'b00, el});
    lz = '0;
    fnd = 1'b0;
    norm = '0;
    if (sum28[27]) begin
      norm = {sum28[27:2], sum28[1] | sum28[0]};
      ex = ex + 10'sd1;
    end else begin
      for (int i = 26; i >= 0; i--)
        if (!fnd && sum28[i]) begin
          lz = 5'(26 - i);
          fnd = 1'b1;
        end
      norm = sum28[26:0] << lz;
      ex = ex - $signed({5'b00000, lz});
    end
    rnd = norm[2] & (norm[1] | norm[0] | norm[3]);
    mr = {1'b0, norm[26:3]} + {24'd0, rnd};
    if (mr[24]) ex = ex + 10'sd1;
    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) res = 32'h7FC00000;
    else if (inf_a)                                      res = {sa, 8'hFF, 23'd0};
    else if (inf_b)                                      res = {sb, 8'hFF, 23'd0};
    else if (sum28 == 28'd0)                             res = {sl & ss, 31'd0};
    else if (ex >= 10'sd255)                             res = {sl, 8'hFF, 23'd0};
    else if (ex <= 10'sd0)                               res = {sl, 31'd0};
    else res = {sl, ex[7:0], mr[24] ? mr[23:1] : mr[22:0]};
  end

  // Result delay line.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) pipe_q <= '0;
    else begin
      pipe_q[0] <= res;
      for (int i = 1; i < Stages; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q = pipe_q[Stages-1];
endmodule
`endif

module acc_multichan #(
  parameter int DataWidth  = 32,
  parameter int Channels   = 8,
  parameter int ChanWidth  = 3,
  parameter int AddLatency = 7,
  parameter int LenWidth   = 8,
  parameter int OutDepth   = 4
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 sclr,
  input  logic [LenWidth-1:0]  AccLen,
  input  logic                 DataInValid,
  input  logic [DataWidth-1:0] DataIn,
  input  logic [ChanWidth-1:0] ChanIn,
  output logic                 DataInRdy,
  output logic                 DataOutValid,
  input  logic                 DataOutRdy,
  output logic [DataWidth-1:0] DataOut,
  output logic [ChanWidth-1:0] ChanOut
);
  localparam int PtrW  = $clog2(OutDepth);
  localparam int UsedW = PtrW + 1;

  logic [Channels-1:0]                busy_q;
  logic [Channels-1:0][LenWidth-1:0]  cnt_q;
  logic [Channels-1:0][DataWidth-1:0] acc_q;
  logic [AddLatency-1:0]                tvld_q, tlast_q;
  logic [AddLatency-1:0][ChanWidth-1:0] tchan_q;
  logic [DataWidth-1:0] fdata_q [OutDepth];
  logic [ChanWidth-1:0] fchan_q [OutDepth];
  logic [PtrW:0]        wptr_q, rptr_q;
  logic [UsedW-1:0]     used_q, used_d;

  logic [LenWidth-1:0]  len_m1;
  logic                 is_last, no_credit, issue, wb, wb_last, pop;
  logic [ChanWidth-1:0] wb_chan;
  logic [DataWidth-1:0] op_a, op_b, sum;

  assign len_m1    = (AccLen == '0) ? '0 : AccLen - 1'b1;
  assign is_last   = cnt_q[ChanIn] == len_m1;
  // used_q counts queued results plus last-beat sums still in the adder.
  assign no_credit = used_q == UsedW'(OutDepth);
  assign DataInRdy = ~aclr & ~sclr & ~busy_q[ChanIn] & ~(is_last & no_credit);
  assign issue     = DataInValid & DataInRdy;
  assign op_a      = DataIn;
  assign op_b      = (cnt_q[ChanIn] == '0) ? '0 : acc_q[ChanIn];
  assign wb        = tvld_q[AddLatency-1];
  assign wb_last   = wb & tlast_q[AddLatency-1];
  assign wb_chan   = tchan_q[AddLatency-1];
  assign DataOutValid = wptr_q != rptr_q;
  assign pop       = DataOutValid & DataOutRdy;
  assign DataOut   = fdata_q[rptr_q[PtrW-1:0]];
  assign ChanOut   = fchan_q[rptr_q[PtrW-1:0]];

`ifdef ACC_INT_ADD_EN
  logic [AddLatency-1:0][DataWidth-1:0] isum_q;

  // Integer adder: add in the first stage, then delay to match the tag path.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) isum_q <= '0;
    else begin
      isum_q[0] <= op_a + op_b;
      for (int i = 1; i < AddLatency; i++) isum_q[i] <= isum_q[i-1];
    end
  end
  assign sum = isum_q[AddLatency-1];
`else
  FP_ADD u_fp_add (.clk(clk), .aclr(aclr), .a(op_a), .b(op_b), .q(sum));
`endif

  // Per-channel partial sums, beat counters and in-flight flags.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      busy_q <= '0; cnt_q <= '0; acc_q <= '0;
    end else if (sclr) begin
      busy_q <= '0; cnt_q <= '0; acc_q <= '0;
    end else begin
      if (wb) begin
        acc_q[wb_chan]  <= sum;
        busy_q[wb_chan] <= 1'b0;
      end
      // A busy channel cannot issue, so this never collides with the write-back.
      if (issue) begin
        busy_q[ChanIn] <= 1'b1;
        cnt_q[ChanIn]  <= is_last ? '0 : cnt_q[ChanIn] + 1'b1;
      end
    end
  end

  // Tag pipeline running alongside the adder.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      tvld_q <= '0; tlast_q <= '0; tchan_q <= '0;
    end else if (sclr) begin
      tvld_q <= '0;
    end else begin
      tvld_q[0]  <= issue;
      tlast_q[0] <= is_last;
      tchan_q[0] <= ChanIn;
      for (int i = 1; i < AddLatency; i++) begin
        tvld_q[i]  <= tvld_q[i-1];
        tlast_q[i] <= tlast_q[i-1];
        tchan_q[i] <= tchan_q[i-1];
      end
    end
  end

  // Output FIFO: pushed by completed tiles, popped by the downstream handshake.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wptr_q <= '0; rptr_q <= '0;
      for (int i = 0; i < OutDepth; i++) begin
        fdata_q[i] <= '0;
        fchan_q[i] <= '0;
      end
    end else if (sclr) begin
      wptr_q <= '0; rptr_q <= '0;
    end else begin
      if (wb_last) begin
        fdata_q[wptr_q[PtrW-1:0]] <= sum;
        fchan_q[wptr_q[PtrW-1:0]] <= wb_chan;
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Credit count: reserve on a last-beat issue, release on pop.
  always_comb begin
    used_d = used_q;
    if ((issue & is_last) & ~pop)      used_d = used_q + 1'b1;
    else if (pop & ~(issue & is_last)) used_d = used_q - 1'b1;
  end

  // Credit register.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr)      used_q <= '0;
    else if (sclr) used_q <= '0;
    else           used_q <= used_d;
  end
endmodule

// File: tb/tb_acc_multichan.sv
// Directed bench for acc_multichan. Dut "a" uses the default OutDepth of 4,
// dut "b" uses OutDepth 8 for the interleaved round-robin stream.
module tb_acc_multichan;
  logic        clk = 1'b0, aclr = 1'b0, sclr = 1'b0;
  logic [7:0]  AccLen = 8'd1;
  logic        vld_a = 1'b0, vld_b = 1'b0, DataOutRdy = 1'b0;
  logic [31:0] DataIn = '0;
  logic [2:0]  ChanIn = '0;
  logic        rdy_a, dov_a, rdy_b, dov_b;
  logic [31:0] dout_a, dout_b;
  logic [2:0]  cout_a, cout_b;
  int checks = 0, failures = 0, cyc = 0;

  acc_multichan u_dut_a (
    .clk(clk), .aclr(aclr), .sclr(sclr), .AccLen(AccLen),
    .DataInValid(vld_a), .DataIn(DataIn), .ChanIn(ChanIn), .DataInRdy(rdy_a),
    .DataOutValid(dov_a), .DataOutRdy(DataOutRdy), .DataOut(dout_a), .ChanOut(cout_a));

  acc_multichan #(.OutDepth(8)) u_dut_b (
    .clk(clk), .aclr(aclr), .sclr(sclr), .AccLen(AccLen),
    .DataInValid(vld_b), .DataIn(DataIn), .ChanIn(ChanIn), .DataInRdy(rdy_b),
    .DataOutValid(dov_b), .DataOutRdy(DataOutRdy), .DataOut(dout_b), .ChanOut(cout_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Encoding of a small non-negative integer in the adder's number format.
  function automatic logic [31:0] V(input int n);
`ifdef ACC_INT_ADD_EN
    return 32'(n);
`else
    int e;
    logic [31:0] m;
    if (n == 0) return 32'd0;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
`endif
  endfunction

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic b8, input int ch, input logic [31:0] d);
    int n;
    n = 0;
    ChanIn = 3'(ch); DataIn = d;
    if (b8) vld_b = 1'b1; else vld_a = 1'b1;
    #1;
    while (!(b8 ? rdy_b : rdy_a) && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL send_timeout ch=%0d got_rdy=0 want_rdy=1", ch);
    end else begin
      @(posedge clk); #1;
    end
    vld_a = 1'b0; vld_b = 1'b0;
  endtask

  task automatic wait_out(input logic b8, output logic ok);
    int n;
    n = 0;
    while (!(b8 ? dov_b : dov_a) && n < 100) begin @(posedge clk); #1; n++; end
    ok = b8 ? dov_b : dov_a;
  endtask

  task automatic pop_one();
    DataOutRdy = 1'b1;
    @(posedge clk); #1;
    DataOutRdy = 1'b0;
  endtask

  task automatic test_reset();
    #1 aclr = 1'b1;
    #1;
    checks++; if (rdy_a !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b want=0", rdy_a); end
    checks++; if (dov_a !== 1'b0) begin failures++; $display("FAIL reset_dov got=%b want=0", dov_a); end
    checks++; if (dout_a !== 32'd0) begin failures++; $display("FAIL reset_dout got=%h want=0", dout_a); end
    checks++; if (cout_a !== 3'd0) begin failures++; $display("FAIL reset_cout got=%0d want=0", cout_a); end
    @(posedge clk); @(posedge clk); #1;
    aclr = 1'b0;
    #1;
    checks++; if (rdy_a !== 1'b1) begin failures++; $display("FAIL reset_rdy_release got=%b want=1", rdy_a); end
  endtask

  task automatic test_single_tile();
    int t0, lowc;
    logic ok;
    t0 = 0;
    AccLen = 8'd4; DataOutRdy = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      ChanIn = 3'd0; DataIn = V(b); vld_a = 1'b1;
      #1;
      checks++; if (rdy_a !== 1'b1) begin failures++; $display("FAIL tile_rdy beat=%0d got=%b want=1", b, rdy_a); end
      @(posedge clk); #1;
      if (b == 1) t0 = cyc;
      lowc = 0;
      while (!rdy_a && lowc < 20) begin @(posedge clk); #1; lowc++; end
      vld_a = 1'b0;
      checks++; if (lowc !== 7) begin failures++; $display("FAIL tile_busy beat=%0d got=%0d want=7", b, lowc); end
    end
    wait_out(1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL tile_out_timeout got=0 want=1"); end
    checks++; if (cyc - t0 !== 31) begin failures++; $display("FAIL tile_latency got=%0d want=31", cyc - t0); end
    checks++; if (dout_a !== V(10)) begin failures++; $display("FAIL tile_sum got=%h want=%h", dout_a, V(10)); end
    checks++; if (cout_a !== 3'd0) begin failures++; $display("FAIL tile_chan got=%0d want=0", cout_a); end
    pop_one();
    checks++; if (dov_a !== 1'b0) begin failures++; $display("FAIL tile_pop_dov got=%b want=0", dov_a); end
  endtask

  task automatic test_fp_ones();
    logic ok;
    logic [31:0] exp_v;
`ifdef ACC_INT_ADD_EN
    exp_v = 32'hBE800000;
`else
    exp_v = 32'h40400000;
`endif
    AccLen = 8'd3;
    for (int i = 0; i < 3; i++) send(1'b0, 2, 32'h3F800000);
    wait_out(1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ones_timeout got=0 want=1"); end
    checks++; if (dout_a !== exp_v) begin failures++; $display("FAIL ones_sum got=%h want=%h", dout_a, exp_v); end
    checks++; if (cout_a !== 3'd2) begin failures++; $display("FAIL ones_chan got=%0d want=2", cout_a); end
    pop_one();
  endtask

  task automatic test_round_robin();
    int stalls, got, n;
    stalls = 0; got = 0; n = 0;
    AccLen = 8'd2; DataOutRdy = 1'b1; vld_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ChanIn = 3'(i % 8); DataIn = V(i % 8 + 1);
      #1;
      if (!rdy_b) stalls++;
      @(posedge clk); #1;
    end
    vld_b = 1'b0;
    checks++; if (stalls !== 0) begin failures++; $display("FAIL rr_stalls got=%0d want=0", stalls); end
    while (got < 8 && n < 60) begin
      if (dov_b) begin
        checks++; if (dout_b !== V(2 * (got + 1))) begin failures++; $display("FAIL rr_sum idx=%0d got=%h want=%h", got, dout_b, V(2 * (got + 1))); end
        checks++; if (cout_b !== 3'(got)) begin failures++; $display("FAIL rr_chan idx=%0d got=%0d want=%0d", got, cout_b, got); end
        got++;
      end
      @(posedge clk); #1; n++;
    end
    DataOutRdy = 1'b0;
    checks++; if (got !== 8) begin failures++; $display("FAIL rr_count got=%0d want=8", got); end
  endtask

  task automatic test_backpressure();
    int hi, got, n;
    hi = 0;
    AccLen = 8'd1; DataOutRdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ChanIn = 3'(c); DataIn = V(c + 1); vld_a = 1'b1;
      #1;
      checks++; if (rdy_a !== 1'b1) begin failures++; $display("FAIL bp_accept ch=%0d got=%b want=1", c, rdy_a); end
      @(posedge clk); #1;
    end
    ChanIn = 3'd4; DataIn = V(5);
    for (int i = 0; i < 15; i++) begin
      #1; if (rdy_a) hi++;
      @(posedge clk); #1;
    end
    vld_a = 1'b0;
    checks++; if (hi !== 0) begin failures++; $display("FAIL bp_block got_rdy_cycles=%0d want=0", hi); end
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) for (int c = 4; c < 8; c++) send(1'b0, c, V(c + 1));
      DataOutRdy = 1'b1; got = 0; n = 0;
      while (got < 4 && n < 40) begin
        if (dov_a) begin
          checks++; if (dout_a !== V(ph * 4 + got + 1)) begin failures++; $display("FAIL bp_sum idx=%0d got=%h want=%h", ph * 4 + got, dout_a, V(ph * 4 + got + 1)); end
          checks++; if (cout_a !== 3'(ph * 4 + got)) begin failures++; $display("FAIL bp_chan idx=%0d got=%0d want=%0d", ph * 4 + got, cout_a, ph * 4 + got); end
          got++;
        end
        @(posedge clk); #1; n++;
      end
      DataOutRdy = 1'b0;
      checks++; if (got !== 4) begin failures++; $display("FAIL bp_drain phase=%0d got=%0d want=4", ph, got); end
    end
  endtask

  task automatic test_sclr();
    int seen;
    logic ok;
    seen = 0;
    AccLen = 8'd2; DataOutRdy = 1'b0;
    send(1'b0, 0, V(7));
    @(posedge clk); #1;
    @(posedge clk); #1;
    ChanIn = 3'd5; sclr = 1'b1;
    #1;
    checks++; if (rdy_a !== 1'b0) begin failures++; $display("FAIL sclr_rdy got=%b want=0", rdy_a); end
    @(posedge clk); #1;
    sclr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (dov_a) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL sclr_no_output got=%0d want=0", seen); end
    send(1'b0, 0, V(5));
    send(1'b0, 0, V(6));
    wait_out(1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL sclr_timeout got=0 want=1"); end
    checks++; if (dout_a !== V(11)) begin failures++; $display("FAIL sclr_sum got=%h want=%h", dout_a, V(11)); end
    pop_one();
  endtask

  task automatic test_aclr();
    logic ok;
    AccLen = 8'd2; DataOutRdy = 1'b0;
    send(1'b0, 0, V(1)); send(1'b0, 1, V(1)); send(1'b0, 2, V(1)); send(1'b0, 3, V(9));
    send(1'b0, 0, V(2)); send(1'b0, 1, V(2)); send(1'b0, 2, V(2));
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    checks++; if (dov_a !== 1'b1) begin failures++; $display("FAIL aclr_queued got=%b want=1", dov_a); end
    #3 aclr = 1'b1;
    #1;
    checks++; if (dov_a !== 1'b0) begin failures++; $display("FAIL aclr_dov got=%b want=0", dov_a); end
    checks++; if (rdy_a !== 1'b0) begin failures++; $display("FAIL aclr_rdy got=%b want=0", rdy_a); end
    checks++; if (dout_a !== 32'd0) begin failures++; $display("FAIL aclr_dout got=%h want=0", dout_a); end
    @(posedge clk); #1;
    aclr = 1'b0;
    send(1'b0, 3, V(5));
    send(1'b0, 3, V(6));
    wait_out(1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL aclr_timeout got=0 want=1"); end
    checks++; if (dout_a !== V(11)) begin failures++; $display("FAIL aclr_sum got=%h want=%h", dout_a, V(11)); end
    checks++; if (cout_a !== 3'd3) begin failures++; $display("FAIL aclr_chan got=%0d want=3", cout_a); end
    pop_one();
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_fp_ones();
    test_round_robin();
    test_backpressure();
    test_sclr();
    test_aclr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/acc_multichan.md
# acc_multichan

Multi-channel, parameterised accumulator. It sums fixed-length tiles of input beats independently for up to `Channels` interleaved streams. It shares one pipelined adder across all channels and emits one tagged result per completed tile through a ready/valid output FIFO. It sits between the MAC/product stage and the result write-back path, and keeps the adder fully busy when channels are interleaved.

## Interface
- `DataWidth`, 32, operand/result width
- `Channels`, 8, independent accumulation channels (power of 2)
- `ChanWidth`, 3, log2(`Channels`)
- `AddLatency`, 7, adder pipeline depth in cycles; must be 7 when the FP adder is used
- `LenWidth`, 8, width of the tile-length input
- `OutDepth`, 4, output FIFO depth (power of 2)
- `clk`, in, 1, clock
- `aclr`, in, 1, reset: asynchronous, active-high
- `sclr`, in, 1, synchronous clear
- `AccLen`, in, `LenWidth`, beats per tile; 0 treated as 1; changed only while idle
- `DataInValid`, in, 1, input beat valid
- `DataIn`, in, `DataWidth`, input operand
- `ChanIn`, in, `ChanWidth`, channel tag of the input beat
- `DataInRdy`, out, 1, beat accepted when `DataInValid & DataInRdy`
- `DataOutValid`, out, 1, output FIFO non-empty
- `DataOutRdy`, in, 1, downstream ready
- `DataOut`, out, `DataWidth`, tile sum
- `ChanOut`, out, `ChanWidth`, channel of `DataOut`

## Operation
- Per-channel state:
  - `acc[c]`: partial sum.
  - `cnt[c]`: beats issued in the current tile.
  - `busy[c]`: a sum for channel c is in flight.
- Issue on handshake:
  - Adder operands are `DataIn` and (`cnt[c]==0` ? 0 : `acc[c]`).
  - The pipeline carries tag {valid, chan, last}, with last = (`cnt[c]==AccLen-1`).
  - Set `busy[c]`; increment `cnt[c]`, or set it to 0 when last.
- Write-back, when the tag exits the pipeline:
  - `acc[chan] <=` result; clear `busy[chan]`.
  - If last, push {result, chan} into the output FIFO.
- Channels have no ordering constraint. Outputs appear in tile-completion order.
- `DataInRdy` = `~aclr & ~sclr & ~busy[ChanIn] & ~(issuing_last & no_credit)`.
  - This is a combinational function of `ChanIn`.
  - no_credit = (FIFO occupancy + in-flight last tags) == `OutDepth`. The FIFO therefore can never overflow.
- Write-back and FIFO pop can occur in the same cycle; occupancy is unchanged.
- A FIFO push and a credit-gated issue in the same cycle use the occupancy before the edge. This is conservative, never an overflow.
- `sclr` (priority below `aclr`): clear all `cnt`, `busy`, `acc`, pipeline tag valids and the FIFO. Any in-flight results are discarded.
- `aclr` asserted mid-operation behaves the same as `sclr`, but asynchronously.

## Timing
- Reset values:
  - `DataOutValid`=0, `DataOut`=0, `ChanOut`=0.
  - `DataInRdy`=0 while `aclr` is high, and 1 after release when `DataInValid` is low or the channel is idle.
- Handshake at edge k: write-back and FIFO push at edge k+`AddLatency`. `DataOutValid` rises after that edge.
- Same channel: next beat accepted at edge k+`AddLatency`+1 at the earliest.
- `Channels` ≥ `AddLatency`+1 with round-robin `ChanIn` sustains one beat per cycle.
- Tile latency (first beat to output valid), single channel: (`AccLen`-1)·(`AddLatency`+1) + `AddLatency` cycles.
- Output pop: `DataOut`/`ChanOut` advance on the edge where `DataOutValid & DataOutRdy` holds.

## Configuration
- `ACC_INT_ADD_EN` defined:
  - The adder is an internal `AddLatency`-stage two's-complement integer adder, wrapping modulo 2^`DataWidth`.
  - It is reset by `aclr` and its tag valids are cleared by `sclr`.
- `ACC_INT_ADD_EN` undefined:
  - The adder is `FP_ADD` (IEEE-754 single, 7 stages), with `aclr` wired to it.
  - `DataWidth` must be 32 and `AddLatency` must be 7.

## Test plan
- Int mode, `AccLen`=4, channel 0: beats 1,2,3,4.
  - Expect one output `DataOut`=10, `ChanOut`=0.
  - Expect `DataInRdy` low for 7 cycles after each handshake.
- Int mode, `AccLen`=2, 8 channels round-robin, `DataIn`=c+1 per beat, 16 beats.
  - Expect no stall.
  - Expect outputs 2,4,…,16 with `ChanOut` 0..7 in order.
- FP mode, `AccLen`=3, beats 0x3F800000 ×3.
  - Expect `DataOut`=0x40400000 (3.0).
- Int mode, `OutDepth`=4, `AccLen`=1, `DataOutRdy`=0, beats to channels 0..7.
  - Expect exactly 4 accepted, then `DataInRdy`=0.
  - Raising `DataOutRdy` drains 4 results, then intake resumes.
- Int mode, `AccLen`=2: `sclr` asserted 3 cycles after the first beat of channel 0.
  - Expect no output.
  - A following tile of 5,6 outputs 11 (the stale partial sum is not reused).
- `aclr` pulse while 3 results are queued.
  - Expect `DataOutValid`=0 immediately (asynchronously).
  - Expect all channel counts restarted on the next tile.
